// File: rtl/rst_req_filter.sv
// Board reset request filter: synchronises a bouncy active-low request, rejects short
// glitches, stretches accepted requests and keeps saturating accept/reject counts.
module rst_req_filter #(
  parameter int SYNC_STAGES = 2,
  parameter int MIN_LOW     = 16,
  parameter int HOLD_CYC    = 32
) (
  input  logic       clk_25m,
  input  logic       rst_n,
  input  logic       req_rst_n,
  output logic       sys_rst_n,
  output logic       busy,
  output logic [7:0] acc_cnt,
  output logic [7:0] glitch_cnt
);

  localparam logic [1:0] ST_RUN  = 2'd0;
  localparam logic [1:0] ST_QUAL = 2'd1;
  localparam logic [1:0] ST_HOLD = 2'd2;

  localparam logic [7:0] MIN_LAST  = 8'(MIN_LOW - 1);
  localparam logic [7:0] HOLD_LAST = 8'(HOLD_CYC - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   req_s;
  logic [1:0]             state, state_d;
  logic [7:0]             cnt, cnt_d;
  logic                   acc_inc, gl_inc;

  assign req_s = sync_q[SYNC_STAGES-1];

  // Synchroniser idles high so a reset of this block never looks like a request.
  always_ff @(posedge clk_25m or negedge rst_n) begin
    if (!rst_n) sync_q <= '1;
    else        sync_q <= {sync_q[SYNC_STAGES-2:0], req_rst_n};
  end

  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    acc_inc = 1'b0;
    gl_inc  = 1'b0;
    case (state)
      ST_RUN: begin
        if (!req_s) begin
          if (MIN_LOW == 1) begin
            state_d = ST_HOLD;
            cnt_d   = 8'd0;
            acc_inc = 1'b1;
          end else begin
            state_d = ST_QUAL;
            cnt_d   = 8'd1;
          end
        end
      end
      ST_QUAL: begin
        if (req_s) begin
          state_d = ST_RUN;
          cnt_d   = 8'd0;
          gl_inc  = 1'b1;
        end else if (cnt == MIN_LAST) begin
          state_d = ST_HOLD;
          cnt_d   = 8'd0;
          acc_inc = 1'b1;
        end else begin
          cnt_d = cnt + 8'd1;
        end
      end
      ST_HOLD: begin
        // A renewed low restarts the stretch but is not a new request.
        if (!req_s) begin
          cnt_d = 8'd0;
        end else if (cnt == HOLD_LAST) begin
          state_d = ST_RUN;
          cnt_d   = 8'd0;
        end else begin
          cnt_d = cnt + 8'd1;
        end
      end
      default: begin
        state_d = ST_HOLD;
        cnt_d   = 8'd0;
      end
    endcase
  end

  always_ff @(posedge clk_25m or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_HOLD;
      cnt        <= 8'd0;
      sys_rst_n  <= 1'b0;
      busy       <= 1'b1;
      acc_cnt    <= 8'd0;
      glitch_cnt <= 8'd0;
    end else begin
      state     <= state_d;
      cnt       <= cnt_d;
      sys_rst_n <= (state_d != ST_HOLD);
      busy      <= (state_d != ST_RUN);
      if (acc_inc && acc_cnt != 8'hFF)   acc_cnt    <= acc_cnt + 8'd1;
      if (gl_inc && glitch_cnt != 8'hFF) glitch_cnt <= glitch_cnt + 8'd1;
    end
  end

endmodule
